// File: rtl/global_avg_8x8_bcast.sv
// Broadcast of one signed value per channel into a DxD row-major raster, each beat value/(D*D).
// Small input FIFO decouples the upstream producer from downstream backpressure.
module global_avg_8x8_bcast #(
    parameter int D          = 8,
    parameter int data_width = 32,
    parameter int FD         = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic [data_width-1:0]   pxl_in,
    output logic                    ready_in,
    input  logic                    ready_out,
    output logic [data_width-1:0]   pxl_out,
    output logic                    valid_out,
    output logic                    last_out,
    output logic [$clog2(D)-1:0]    row_out,
    output logic [$clog2(D)-1:0]    col_out
);

    localparam int L  = $clog2(D);
    localparam int TL = 2 * L;
    localparam int T  = D * D;
    localparam int FA = (FD > 1) ? $clog2(FD) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    logic [data_width-1:0] mem [FD];
    logic [FA-1:0]         wr_ptr;
    logic [FA-1:0]         rd_ptr;
    logic [FA:0]           count;
    logic [TL-1:0]         cnt;
    logic [data_width-1:0] hold;
    state_t                state;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic last_beat;

    assign full      = (count == (FA+1)'(FD));
    assign empty     = (count == '0);
    assign ready_in  = reset && !full;
    assign push      = valid_in && ready_in;
    assign last_beat = (cnt == TL'(T - 1));
    // Pop either to start a frame from idle or to chain the next frame on the last transfer.
    assign pop       = !empty && ((state == IDLE) ||
                                  (state == STREAM && ready_out && last_beat));

    // NOTE: storage array carries no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pxl_in;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (FA+1)'(push) - (FA+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        hold  <= data_width'($signed(mem[rd_ptr]) >>> TL);
                        cnt   <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (ready_out) begin
                        if (last_beat) begin
                            cnt <= '0;
                            if (pop) begin
                                hold <= data_width'($signed(mem[rd_ptr]) >>> TL);
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign valid_out = (state == STREAM);
    assign pxl_out   = hold;
    assign row_out   = cnt[TL-1:L];
    assign col_out   = cnt[L-1:0];
    assign last_out  = valid_out && last_beat;

endmodule

// File: tb/tb_global_avg_8x8_bcast.sv
// Randomized and directed bench for global_avg_8x8_bcast against a queue-based frame model.
module tb_global_avg_8x8_bcast;

    localparam int D  = 8;
    localparam int DW = 32;
    localparam int FD = 2;
    localparam int T  = D * D;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] pxl_in = '0;
    logic          ready_in;
    logic          ready_out;
    logic          ready_out_drv = 1'b0;
    logic          rand_ready = 1'b0;
    logic          rand_bit = 1'b0;
    logic [DW-1:0] pxl_out;
    logic          valid_out;
    logic          last_out;
    logic [2:0]    row_out;
    logic [2:0]    col_out;

    assign ready_out = rand_ready ? rand_bit : ready_out_drv;

    global_avg_8x8_bcast #(.D(D), .data_width(DW), .FD(FD)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .pxl_in    (pxl_in),
        .ready_in  (ready_in),
        .ready_out (ready_out),
        .pxl_out   (pxl_out),
        .valid_out (valid_out),
        .last_out  (last_out),
        .row_out   (row_out),
        .col_out   (col_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Floor division by T, done with plain integer arithmetic.
    function automatic logic [31:0] bcast(input logic [31:0] v);
        longint sv, q;
        sv = longint'($signed(v));
        q  = sv / T;
        if ((sv % T != 0) && (sv < 0)) q = q - 1;
        return q[31:0];
    endfunction

    logic [DW-1:0] exp_q[$];
    int            beat = 0;
    int            frames_done = 0;
    int            xfers = 0;
    int            run = 0;
    int            last_run = 0;
    bit            stalled = 1'b0;
    logic [DW-1:0] prev_pxl;
    logic [2:0]    prev_row;
    logic [2:0]    prev_col;
    logic          prev_last;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            beat    = 0;
            stalled = 1'b0;
            run     = 0;
        end else begin
            if (stalled) begin
                check("stall_valid", valid_out, 1'b1);
                check("stall_pxl",   pxl_out,   prev_pxl);
                check("stall_rc",    {row_out, col_out, last_out}, {prev_row, prev_col, prev_last});
            end
            if (valid_out && ready_out) begin
                xfers++;
                run++;
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 1'b1, 1'b0);
                end else begin
                    check("beat_pxl",  pxl_out,  bcast(exp_q[0]));
                    check("beat_row",  row_out,  64'(beat / D));
                    check("beat_col",  col_out,  64'(beat % D));
                    check("beat_last", last_out, 64'(beat == T - 1));
                    beat++;
                    if (beat == T) begin
                        beat = 0;
                        frames_done++;
                        void'(exp_q.pop_front());
                    end
                end
            end else if (run > 0) begin
                last_run = run;
                run = 0;
            end
            if (valid_in && ready_in) exp_q.push_back(pxl_in);
            stalled   = valid_out && !ready_out;
            prev_pxl  = pxl_out;
            prev_row  = row_out;
            prev_col  = col_out;
            prev_last = last_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        bit done = 1'b0;
        valid_in = 1'b1;
        pxl_in   = v;
        for (int i = 0; i < 600 && !done; i++) begin
            if (ready_in) done = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        if (!done) check("push_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (!valid_out && exp_q.size() == 0) done = 1'b1;
            else tick();
        end
        if (!done) check("idle_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int f0, x0, acc;
        bit found;

        // Reset values
        #12;
        check("rst_ready_in",  ready_in,  1'b0);
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_pxl_out",   pxl_out,   32'h0);
        check("rst_rc_last",   {row_out, col_out, last_out}, 7'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_rst_ready", ready_in, 1'b1);

        // Single frame of 1s with first-beat latency and frame length
        ready_out_drv = 1'b1;
        push(32'd64);
        check("t1_lat_idle", valid_out, 1'b0);
        tick();
        check("t1_first_valid", valid_out, 1'b1);
        check("t1_first_pxl",   pxl_out,   32'd1);
        check("t1_first_rc",    {row_out, col_out}, 6'h0);
        repeat (T - 1) tick();
        check("t1_last_beat", {last_out, row_out, col_out}, {1'b1, 3'd7, 3'd7});
        tick();
        check("t1_end_idle", valid_out, 1'b0);

        // Negative floor and maximum positive value
        push(-32'sd65);
        tick();
        check("t2_neg_pxl", pxl_out, 32'hFFFF_FFFE);
        wait_idle(200);
        push(32'h7FFF_FFFF);
        tick();
        check("t2_max_pxl", pxl_out, 32'h01FF_FFFF);
        wait_idle(200);
        tick();

        // Back-to-back frames with FIFO full
        f0 = frames_done;
        push(32'd640);
        push(32'd1280);
        push(32'd1920);
        check("t3_full_ready", ready_in, 1'b0);
        wait_idle(400);
        tick();
        check("t3_contig_run", last_run, 3 * T);
        check("t3_frames", frames_done - f0, 3);

        // Stalls with a 1,0,0,1 ready pattern
        ready_out_drv = 1'b0;
        x0 = xfers;
        f0 = frames_done;
        push(32'd128);
        for (int i = 0; i < 600 && (xfers - x0) < T; i++) begin
            ready_out_drv = (i % 4 == 0) || (i % 4 == 3);
            tick();
        end
        ready_out_drv = 1'b1;
        wait_idle(200);
        check("t4_xfers", xfers - x0, T);
        check("t4_frames", frames_done - f0, 1);

        // Asynchronous reset mid-frame, then a fresh frame
        push(32'd64);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (valid_out && row_out == 3'd2 && col_out == 3'd4) found = 1'b1;
            else tick();
        end
        check("t5_reach_beat20", found, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_async_valid", valid_out, 1'b0);
        check("t5_async_ready", ready_in,  1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        tick();
        check("t5_rel_state", {ready_in, valid_out, row_out, col_out}, {1'b1, 1'b0, 6'h0});
        push(32'd256);
        tick();
        check("t5_fresh", {valid_out, pxl_out, row_out, col_out}, {1'b1, 32'd4, 6'h0});
        wait_idle(200);

        // Fill under full backpressure: one value streams, FD more wait in the FIFO
        ready_out_drv = 1'b0;
        f0  = frames_done;
        acc = 0;
        valid_in = 1'b1;
        pxl_in   = $urandom;
        for (int i = 0; i < 10; i++) begin
            found = ready_in;
            tick();
            if (found) begin
                acc++;
                pxl_in = $urandom;
            end
        end
        valid_in = 1'b0;
        check("t6_accepted", acc, FD + 1);
        check("t6_ready_low", ready_in, 1'b0);
        ready_out_drv = 1'b1;
        wait_idle(600);
        check("t6_frames", frames_done - f0, FD + 1);

        // Random values with random backpressure and input gaps
        rand_ready = 1'b1;
        f0 = frames_done;
        for (int i = 0; i < 8; i++) begin
            push($urandom);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle(4000);
        rand_ready = 1'b0;
        check("rand_frames", frames_done - f0, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
